// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Single-outstanding APB initiator. Turns a valid/ready request into an APB
// SETUP/ACCESS transfer and reports read data plus error status. A wait-state
// timeout aborts transfers to a slave that never raises pready.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              n_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_write,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  // A zero TIMEOUT disables the abort; keep a 1-bit counter so widths stay legal.
  localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic             r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic             r_rsp_err;
  logic             w_timeout;

  // Abort fires on the last permitted ACCESS cycle; pready is tested first so a
  // late-but-valid slave response still completes normally.
  assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LAST);

  // Transfer sequencer: holds the APB payload and the captured response.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_paddr  <= i_req_addr;
            r_pwrite <= i_req_write;
            r_pwdata <= i_req_wdata;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (i_pready) begin
            r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
            r_rsp_err   <= i_pslverr;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else if (TIMEOUT_EN) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Control strobes decode straight from the state register, so they are
  // glitch-free and drop as soon as reset forces IDLE.
  always_comb begin
    o_req_ready = (r_state == S_IDLE);
    o_psel      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    o_penable   = (r_state == S_ACCESS);
    o_rsp_valid = (r_state == S_RESP);
  end

  assign o_paddr     = r_paddr;
  assign o_pwrite    = r_pwrite;
  assign o_pwdata    = r_pwdata;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge with a cycle-accurate APB slave
// model. Expected response timing and values come from a transaction-level
// model: ACCESS length, abort decision, read data and error flag.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic        pclk;
  logic        nRst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        reqWrite;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int assertCount;
  int failCount;

  logic [31:0] lastAddr;
  logic [31:0] lastRdata;
  logic        lastErr;

  apb_master_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .pclk       (pclk),
    .n_rst      (nRst),
    .i_req_valid(reqValid),
    .o_req_ready(reqReady),
    .i_req_addr (reqAddr),
    .i_req_write(reqWrite),
    .i_req_wdata(reqWdata),
    .o_rsp_valid(rspValid),
    .o_rsp_rdata(rspRdata),
    .o_rsp_err  (rspErr),
    .o_psel     (psel),
    .o_penable  (penable),
    .o_pwrite   (pwrite),
    .o_paddr    (paddr),
    .o_pwdata   (pwdata),
    .i_prdata   (prdata),
    .i_pready   (pready),
    .i_pslverr  (pslverr)
  );

  // Free-running 10-unit clock.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One complete transfer. The slave holds pready low for 'waits' ACCESS
  // cycles, then answers with rd/err. Caller is sampling #1 after an edge in IDLE.
  task automatic applyStimulus(input logic [31:0] addr, input bit wr,
                               input logic [31:0] wd, input int waits,
                               input logic [31:0] rd, input bit err,
                               input bit holdValid);
    bit          aborted;
    int          accLen;
    logic [31:0] expRdata;
    bit          expErr;

    aborted  = (TO != 0) && (waits >= TO);
    accLen   = aborted ? TO : waits + 1;
    expRdata = (aborted || wr) ? 32'h0 : rd;
    expErr   = aborted ? 1'b1 : err;

    checkOutput("idle_ready", 32'(reqReady), 32'd1);
    checkOutput("idle_psel", 32'(psel), 32'd0);
    checkOutput("idle_paddr_hold", paddr, lastAddr);
    checkOutput("idle_rdata_hold", rspRdata, lastRdata);
    checkOutput("idle_err_hold", 32'(rspErr), 32'(lastErr));

    reqValid = 1'b1;
    reqAddr  = addr;
    reqWrite = wr;
    reqWdata = wd;
    pready   = 1'b0;

    @(posedge pclk); #1;
    checkOutput("setup_psel", 32'(psel), 32'd1);
    checkOutput("setup_penable", 32'(penable), 32'd0);
    checkOutput("setup_ready", 32'(reqReady), 32'd0);
    checkOutput("setup_paddr", paddr, addr);
    checkOutput("setup_pwrite", 32'(pwrite), 32'(wr));
    checkOutput("setup_pwdata", pwdata, wd);

    reqValid = holdValid;
    reqAddr  = $urandom;
    reqWrite = 1'($urandom);
    reqWdata = $urandom;

    for (int i = 0; i < accLen; i++) begin
      @(posedge pclk); #1;
      checkOutput("access_psel", 32'(psel), 32'd1);
      checkOutput("access_penable", 32'(penable), 32'd1);
      checkOutput("access_paddr", paddr, addr);
      checkOutput("access_pwrite", 32'(pwrite), 32'(wr));
      checkOutput("access_pwdata", pwdata, wd);
      checkOutput("access_rsp_valid", 32'(rspValid), 32'd0);
      if (i == waits) begin
        pready  = 1'b1;
        prdata  = rd;
        pslverr = err;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end

    @(posedge pclk); #1;
    checkOutput("resp_valid", 32'(rspValid), 32'd1);
    checkOutput("resp_rdata", rspRdata, expRdata);
    checkOutput("resp_err", 32'(rspErr), 32'(expErr));
    checkOutput("resp_psel", 32'(psel), 32'd0);
    checkOutput("resp_penable", 32'(penable), 32'd0);
    checkOutput("resp_ready", 32'(reqReady), 32'd0);
    pready  = 1'b0;
    pslverr = 1'b0;

    @(posedge pclk); #1;
    checkOutput("post_valid_pulse", 32'(rspValid), 32'd0);
    checkOutput("post_ready", 32'(reqReady), 32'd1);
    checkOutput("post_rdata_hold", rspRdata, expRdata);
    checkOutput("post_paddr_hold", paddr, addr);

    lastAddr  = addr;
    lastRdata = expRdata;
    lastErr   = expErr;
    reqValid  = 1'b0;
  endtask

  // Main sequence: reset, directed scenarios, random traffic, reset mid-transfer.
  initial begin
    assertCount = 0;
    failCount   = 0;
    lastAddr    = 32'h0;
    lastRdata   = 32'h0;
    lastErr     = 1'b0;
    nRst        = 1'b0;
    reqValid    = 1'b0;
    reqAddr     = 32'h0;
    reqWrite    = 1'b0;
    reqWdata    = 32'h0;
    prdata      = 32'h0;
    pready      = 1'b0;
    pslverr     = 1'b0;

    repeat (2) @(posedge pclk);
    #1;
    checkOutput("rst_psel", 32'(psel), 32'd0);
    checkOutput("rst_penable", 32'(penable), 32'd0);
    checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
    checkOutput("rst_paddr", paddr, 32'h0);
    checkOutput("rst_pwdata", pwdata, 32'h0);
    checkOutput("rst_rsp_rdata", rspRdata, 32'h0);
    nRst = 1'b1;

    @(posedge pclk); #1;
    checkOutput("rel_ready", 32'(reqReady), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk); #1;
      checkOutput("quiet_psel", 32'(psel), 32'd0);
    end

    $display("[TB] directed transfers");
    applyStimulus(32'h04, 1'b1, 32'hA5, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(32'h0C, 1'b0, 32'h0, 2, 32'h5A, 1'b0, 1'b0);
    applyStimulus(32'h10, 1'b1, 32'h1234, 0, 32'h0, 1'b1, 1'b0);
    applyStimulus(32'h14, 1'b0, 32'h0, 1, 32'hCAFE_0001, 1'b0, 1'b0);
    applyStimulus(32'h18, 1'b0, 32'h0, 20, 32'h7777, 1'b0, 1'b0);
    applyStimulus(32'h1C, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 1'b0);
    applyStimulus(32'h20, 1'b1, 32'h55, TO, 32'h0, 1'b0, 1'b0);

    $display("[TB] back-to-back with req_valid held");
    applyStimulus(32'h100, 1'b1, 32'h11, 0, 32'h0, 1'b0, 1'b1);
    applyStimulus(32'h104, 1'b0, 32'h0, 0, 32'h22, 1'b0, 1'b1);
    applyStimulus(32'h108, 1'b1, 32'h33, 0, 32'h0, 1'b0, 1'b0);

    $display("[TB] random transfers");
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom, 1'($urandom), $urandom, int'($urandom_range(0, TO + 2)),
                    $urandom, 1'($urandom), 1'($urandom));
    end

    $display("[TB] reset during ACCESS");
    reqValid = 1'b1;
    reqAddr  = 32'h200;
    reqWrite = 1'b0;
    reqWdata = 32'h0;
    pready   = 1'b0;
    @(posedge pclk); #1;
    reqValid = 1'b0;
    @(posedge pclk); #1;
    checkOutput("pre_rst_penable", 32'(penable), 32'd1);
    @(posedge pclk); #2;
    nRst = 1'b0;
    #1;
    checkOutput("async_rst_psel", 32'(psel), 32'd0);
    checkOutput("async_rst_penable", 32'(penable), 32'd0);
    checkOutput("async_rst_valid", 32'(rspValid), 32'd0);
    @(posedge pclk); #1;
    checkOutput("in_rst_valid", 32'(rspValid), 32'd0);
    nRst = 1'b1;
    @(posedge pclk); #1;
    checkOutput("after_rst_valid", 32'(rspValid), 32'd0);
    checkOutput("after_rst_ready", 32'(reqReady), 32'd1);
    lastAddr  = 32'h0;
    lastRdata = 32'h0;
    lastErr   = 1'b0;
    applyStimulus(32'h204, 1'b0, 32'h0, 1, 32'h600D_DA7A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
